// File: rtl/count7_pkg.sv
// Shared widths and constants for the count7 counter family.
package count7_pkg;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned CNT_MAX = 6;
  localparam logic [CNT_W-1:0] CNT_ZERO = 3'd0;
endpackage

// File: rtl/count7_dn_next.sv
// Next-count and load-clamp logic for count7_dn; purely combinational.
// Define COUNT7_DN_STOP_EN for one-shot mode (hold at zero instead of wrapping).
module count7_dn_next
  import count7_pkg::*;
#(
  parameter int unsigned TOP = CNT_MAX
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] cnt_next,
  output logic             dec_to_zero
);

  localparam logic [CNT_W-1:0] TopVal = CNT_W'(TOP);

  always_comb begin
    cnt_next    = cnt;
    dec_to_zero = 1'b0;
    if (load) begin
      // Out-of-range loads clamp to TOP so 7 can never be stored.
      cnt_next = (din > TopVal) ? TopVal : din;
    end else if (en) begin
      dec_to_zero = (cnt == 3'd1);
      if (cnt != CNT_ZERO) begin
        cnt_next = cnt - 3'd1;
      end else begin
`ifdef COUNT7_DN_STOP_EN
        cnt_next = CNT_ZERO;
`else
        cnt_next = TopVal;
`endif
      end
    end
  end

endmodule

// File: rtl/count7_dn.sv
// Mod-(TOP+1) down counter with load, cascade borrow and terminal-count pulse.
// Define COUNT7_DN_STOP_EN for one-shot mode: counter parks at zero, BO stays low.
module count7_dn
  import count7_pkg::*;
#(
  parameter int unsigned TOP = CNT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] CNT,
  output logic             BO,
  output logic             TC
);

  generate
    if (TOP < 1 || TOP > CNT_MAX) begin : g_bad_top
      $error("count7_dn: TOP must be in 1..6");
    end
  endgenerate

  localparam logic [CNT_W-1:0] TopVal = CNT_W'(TOP);

  logic [CNT_W-1:0] cnt_next;
  logic             dec_to_zero;

  count7_dn_next #(
    .TOP(TOP)
  ) u_next (
    .cnt        (CNT),
    .en         (en),
    .load       (load),
    .din        (din),
    .cnt_next   (cnt_next),
    .dec_to_zero(dec_to_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      CNT <= TopVal;
      TC  <= 1'b0;
    end else begin
      CNT <= cnt_next;
      TC  <= dec_to_zero;
    end
  end

`ifdef COUNT7_DN_STOP_EN
  assign BO = 1'b0;
`else
  assign BO = en & ~load & (CNT == CNT_ZERO);
`endif

endmodule

// File: tb/tb_count7_dn.sv
// Directed plus random self-checking bench for count7_dn against a behavioural model.
module tb_count7_dn;
  localparam int TOP = 6;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [2:0] din;
  logic [2:0] CNT;
  logic       BO, TC;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: count value and expected terminal-count pulse.
  int m_cnt = TOP;
  int m_tc  = 0;

  count7_dn #(
    .TOP(TOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .load(load),
    .din (din),
    .CNT (CNT),
    .BO  (BO),
    .TC  (TC)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check the borrow, advance the model, check registered outputs.
  task automatic step(input bit r, input bit l, input bit e, input int d);
    int exp_bo;
    rst = r; load = l; en = e; din = 3'(d);
    #1;
`ifdef COUNT7_DN_STOP_EN
    exp_bo = 0;
`else
    exp_bo = (e && !l && m_cnt == 0) ? 1 : 0;
`endif
    check_eq("BO", int'(BO), exp_bo);
    if (r) begin
      m_cnt = TOP; m_tc = 0;
    end else if (l) begin
      m_cnt = (d > TOP) ? TOP : d; m_tc = 0;
    end else if (e) begin
      m_tc = (m_cnt == 1) ? 1 : 0;
`ifdef COUNT7_DN_STOP_EN
      if (m_cnt > 0) m_cnt = m_cnt - 1;
`else
      m_cnt = (m_cnt + TOP) % (TOP + 1);
`endif
    end else begin
      m_tc = 0;
    end
    @(posedge clk);
    #1;
    check_eq("CNT", int'(CNT), m_cnt);
    check_eq("TC", int'(TC), m_tc);
    check_eq("CNT_range", (int'(CNT) <= TOP) ? 1 : 0, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; din = 3'd0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 0, 1, 0);
    step(0, 1, 0, 7);
    step(0, 1, 1, 2);
    step(0, 1, 0, 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    step(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    step(0, 1, 0, 3);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
